threshold_dac_spi: RTL and testbench

- Responder for the threshold write handshake (threshold/wre/rdy) that the channel measurement controller drives.
- Accepts a 16-bit threshold code, serialises it as a 24-bit frame (8-bit command + 16-bit code) to the comparator-reference DAC over a write-only SPI link, then waits a fixed settling time.
- Holds threshold_rdy_o low until the DAC output is valid.
- Sits between the measurement control unit and the DAC pins, one instance per channel.

---
 rtl/threshold_dac_spi.sv | 164 ++++++++++++++++
 tb/tb_threshold_dac_spi.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_dac_spi.sv
// Per-channel threshold responder: takes a 16-bit code over the wre/rdy handshake and writes it
// to the comparator-reference DAC as a 24-bit SPI frame, then waits for the DAC to settle.
module threshold_dac_spi #(
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [7:0]  CMD_WORD      = 8'h00
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic [15:0] threshold_i,
    input  logic        threshold_wre_i,
    output logic        threshold_rdy_o,
    output logic [15:0] dac_code_o,
    output logic        spi_sclk_o,
    output logic        spi_sync_n_o,
    output logic        spi_sdo_o
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShift, StTrail, StSettle} state_e;

    state_e            state_q, state_d;
    logic [4:0]        bit_q, bit_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              phase_q, phase_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [15:0]       code_q, code_d;
    logic              pend_q, pend_d;
    logic [15:0]       pend_code_q, pend_code_d;
    logic [15:0]       dac_q, dac_d;
    logic              rdy_q, rdy_d;
    logic              sclk_q, sclk_d;
    logic              sync_n_q, sync_n_d;
    logic              sdo_q, sdo_d;
    logic              start;
    logic              div_done;
    logic [23:0]       frame_d;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        div_d       = div_q;
        phase_d     = phase_q;
        settle_d    = settle_q;
        code_d      = code_q;
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        dac_d       = dac_q;
        start       = 1'b0;
        div_done    = (div_q == DivLast);

        unique case (state_q)
            StIdle: begin
                start = pend_q;
            end
            StShift: begin
                if (div_done) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 5'd0) begin
                            state_d = StTrail;
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StTrail: begin
                if (div_done) begin
                    div_d    = '0;
                    state_d  = StSettle;
                    settle_d = '0;
                    dac_d    = code_q;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StSettle: begin
                if (settle_q == SetLast) begin
                    if (pend_q) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start) begin
            state_d = StShift;
            code_d  = pend_code_q;
            bit_d   = 5'd23;
            div_d   = '0;
            phase_d = 1'b0;
            pend_d  = 1'b0;
        end

        // Every accepted write lands in the pending slot; the newest code wins.
        if (threshold_wre_i) begin
            pend_d      = 1'b1;
            pend_code_d = threshold_i;
        end

        // Pins are registered from next-state so they leave the block glitch-free.
        frame_d  = {CMD_WORD, code_d};
        rdy_d    = (state_d == StIdle) && !pend_d;
        sync_n_d = !((state_d == StShift) || (state_d == StTrail));
        sclk_d   = (state_d == StShift) && phase_d;
        sdo_d    = (state_d == StShift) ? frame_d[bit_d] : 1'b0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= StIdle;
            bit_q       <= 5'd0;
            div_q       <= '0;
            phase_q     <= 1'b0;
            settle_q    <= '0;
            code_q      <= 16'h0000;
            pend_q      <= 1'b0;
            pend_code_q <= 16'h0000;
            dac_q       <= 16'h0000;
            rdy_q       <= 1'b1;
            sclk_q      <= 1'b0;
            sync_n_q    <= 1'b1;
            sdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            settle_q    <= settle_d;
            code_q      <= code_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            dac_q       <= dac_d;
            rdy_q       <= rdy_d;
            sclk_q      <= sclk_d;
            sync_n_q    <= sync_n_d;
            sdo_q       <= sdo_d;
        end
    end

    assign threshold_rdy_o = rdy_q;
    assign dac_code_o      = dac_q;
    assign spi_sclk_o      = sclk_q;
    assign spi_sync_n_o    = sync_n_q;
    assign spi_sdo_o       = sdo_q;

endmodule

// File: tb/tb_threshold_dac_spi.sv
// Bench for threshold_dac_spi: two instances (default and fast parameters) checked every cycle
// against a timeline model, plus directed latency/frame checks.
module tb_threshold_dac_spi;

    logic        clk = 1'b0;
    logic        arst;
    logic [1:0]  wre;
    logic [15:0] thr [2];
    logic [1:0]  rdy_w, sync_w, sclk_w, sdo_w;
    logic [15:0] dac_w [2];

    always #5 clk = ~clk;

    threshold_dac_spi dut0 (
        .clk_i(clk), .arst_i(arst), .threshold_i(thr[0]), .threshold_wre_i(wre[0]),
        .threshold_rdy_o(rdy_w[0]), .dac_code_o(dac_w[0]), .spi_sclk_o(sclk_w[0]),
        .spi_sync_n_o(sync_w[0]), .spi_sdo_o(sdo_w[0])
    );

    threshold_dac_spi #(.CLK_DIV(1), .SETTLE_CYCLES(1), .CMD_WORD(8'h30)) dut1 (
        .clk_i(clk), .arst_i(arst), .threshold_i(thr[1]), .threshold_wre_i(wre[1]),
        .threshold_rdy_o(rdy_w[1]), .dac_code_o(dac_w[1]), .spi_sclk_o(sclk_w[1]),
        .spi_sync_n_o(sync_w[1]), .spi_sdo_o(sdo_w[1])
    );

    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 0;

    int          p_div [2] = '{2, 1};
    int          p_set [2] = '{8, 1};
    logic [7:0]  p_cmd [2] = '{8'h00, 8'h30};

    // Model: a frame is a timeline of k cycles since it started; writes go to a pending slot.
    bit          m_act [2];
    int          m_k [2];
    logic [15:0] m_code [2];
    bit          m_pend [2];
    logic [15:0] m_pc [2];
    logic [15:0] m_dac [2];

    logic [23:0] mon_sh [2];
    int          mon_n [2];
    logic [1:0]  prev_sclk = 2'b00;
    logic [1:0]  prev_sync = 2'b11;
    logic [23:0] qb0[$], qb1[$];
    int          qn0[$], qn1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int frame_len(input int i);
        return 49 * p_div[i] + p_set[i];
    endfunction

    task automatic model_step(input int i);
        bit start;
        start = 0;
        if (arst) begin
            m_act[i] = 0; m_k[i] = 0; m_code[i] = 0; m_pend[i] = 0; m_pc[i] = 0; m_dac[i] = 0;
        end else begin
            if (m_act[i]) begin
                if (m_k[i] + 1 == frame_len(i)) begin
                    if (m_pend[i]) start = 1;
                    else m_act[i] = 0;
                end else begin
                    m_k[i]++;
                    if (m_k[i] == 49 * p_div[i]) m_dac[i] = m_code[i];
                end
            end else if (m_pend[i]) begin
                start = 1;
            end
            if (start) begin
                m_act[i] = 1; m_k[i] = 0; m_code[i] = m_pc[i]; m_pend[i] = 0;
            end
            if (wre[i]) begin
                m_pend[i] = 1; m_pc[i] = thr[i];
            end
        end
    endtask

    // Returns {rdy, sync_n, sclk, sdo}.
    function automatic logic [3:0] exp_pins(input int i);
        int          d;
        int          k;
        logic [23:0] fr;
        logic        rdy, sy, sc, sd;
        d   = p_div[i];
        k   = m_k[i];
        fr  = {p_cmd[i], m_code[i]};
        rdy = !m_act[i] && !m_pend[i];
        sy  = 1'b1; sc = 1'b0; sd = 1'b0;
        if (arst) begin
            rdy = 1'b1;
        end else if (m_act[i] && k < 49 * d) begin
            sy = 1'b0;
            if (k < 48 * d) begin
                sc = (k % (2 * d)) >= d;
                sd = fr[23 - k / (2 * d)];
            end
        end
        return {rdy, sy, sc, sd};
    endfunction

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0] e;
                e = exp_pins(i);
                check($sformatf("rdy%0d", i), 32'(rdy_w[i]), 32'(e[3]));
                check($sformatf("sync_n%0d", i), 32'(sync_w[i]), 32'(e[2]));
                check($sformatf("sclk%0d", i), 32'(sclk_w[i]), 32'(e[1]));
                check($sformatf("sdo%0d", i), 32'(sdo_w[i]), 32'(e[0]));
                check($sformatf("dac%0d", i), 32'(dac_w[i]), 32'(arst ? 16'h0 : m_dac[i]));
            end
        end
    end

    // Frame capture: bits sampled on SCLK rise, frame closed when SYNC rises.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!sync_w[i] && sclk_w[i] && !prev_sclk[i]) begin
                mon_sh[i] = {mon_sh[i][22:0], sdo_w[i]};
                mon_n[i]++;
            end
            if (sync_w[i] && !prev_sync[i]) begin
                if (i == 0) begin qb0.push_back(mon_sh[i]); qn0.push_back(mon_n[i]); end
                else begin qb1.push_back(mon_sh[i]); qn1.push_back(mon_n[i]); end
                mon_n[i] = 0; mon_sh[i] = 24'h0;
            end
            prev_sclk[i] = sclk_w[i];
            prev_sync[i] = sync_w[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input int i, input logic [15:0] c);
        wre[i] = 1'b1; thr[i] = c;
        tick();
        wre[i] = 1'b0; thr[i] = 16'($urandom);
    endtask

    task automatic clear_q();
        qb0.delete(); qn0.delete(); qb1.delete(); qn1.delete();
    endtask

    task automatic wait_rdy(input int i, output int n);
        n = -1;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            if (rdy_w[i]) begin n = c; break; end
        end
        if (n < 0) check($sformatf("rdy_timeout%0d", i), 32'd0, 32'd1);
    endtask

    task automatic frame_latency(input int i, input logic [15:0] c, output int rdy_at,
                                 output int low);
        write(i, c);
        check("rdy_low_after_accept", 32'(rdy_w[i]), 32'd0);
        rdy_at = -1;
        low    = 0;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (!sync_w[i]) low++;
            if (rdy_w[i]) begin rdy_at = n; break; end
        end
    endtask

    int rdy_at, low, n;

    initial begin
        arst = 1'b1; wre = 2'b00; thr[0] = 16'h0; thr[1] = 16'h0;
        for (int i = 0; i < 2; i++) begin mon_sh[i] = 24'h0; mon_n[i] = 0; end
        repeat (3) tick();
        check("reset_rdy", 32'(rdy_w[0]), 32'd1);
        check("reset_sync_n", 32'(sync_w[0]), 32'd1);
        check("reset_sclk", 32'(sclk_w[0]), 32'd0);
        check("reset_sdo", 32'(sdo_w[0]), 32'd0);
        check("reset_dac", 32'(dac_w[0]), 32'h0);
        arst = 1'b0;
        chk_en = 1;
        tick();

        // Single write with default parameters
        clear_q();
        frame_latency(0, 16'hA5C3, rdy_at, low);
        check("t1_rdy_latency", 32'(rdy_at), 32'd107);
        check("t1_sync_low_cycles", 32'(low), 32'd98);
        check("t1_frame_count", 32'(qn0.size()), 32'd1);
        if (qn0.size() > 0) begin
            check("t1_sclk_edges", 32'(qn0[0]), 32'd24);
            check("t1_frame_bits", 32'(qb0[0]), 32'h00A5C3);
        end
        check("t1_dac_code", 32'(dac_w[0]), 32'hA5C3);

        // Back-to-back writes: the middle one is overwritten while pending
        clear_q();
        write(0, 16'h0001);
        repeat (9) tick();
        write(0, 16'h0002);
        repeat (9) tick();
        write(0, 16'h0003);
        wait_rdy(0, n);
        check("t2_rdy_after_second", 32'(n), 32'd193);
        check("t2_frame_count", 32'(qb0.size()), 32'd2);
        if (qb0.size() == 2) begin
            check("t2_frame0", 32'(qb0[0]), 32'h000001);
            check("t2_frame1", 32'(qb0[1]), 32'h000003);
        end

        // Write on the final settle cycle
        clear_q();
        write(0, 16'h1111);
        repeat (106) tick();
        write(0, 16'hFFFF);
        check("t3_rdy_after_last_settle", 32'(rdy_w[0]), 32'd0);
        check("t3_sync_gap", 32'(sync_w[0]), 32'd1);
        tick();
        check("t3_sync_restart", 32'(sync_w[0]), 32'd0);
        check("t3_rdy_held", 32'(rdy_w[0]), 32'd0);
        wait_rdy(0, n);
        check("t3_rdy_latency", 32'(n), 32'd106);
        check("t3_frame_count", 32'(qb0.size()), 32'd2);
        if (qb0.size() == 2) check("t3_frame1", 32'(qb0[1]), 32'h00FFFF);

        // Reset mid-frame after 10 SCLK edges
        clear_q();
        write(0, 16'h5A5A);
        for (int c = 0; c < 200; c++) begin
            if (mon_n[0] >= 10) break;
            tick();
        end
        arst = 1'b1;
        #1;
        check("t4_sync_n", 32'(sync_w[0]), 32'd1);
        check("t4_sclk", 32'(sclk_w[0]), 32'd0);
        check("t4_rdy", 32'(rdy_w[0]), 32'd1);
        check("t4_dac", 32'(dac_w[0]), 32'h0);
        tick();
        arst = 1'b0;
        tick();
        check("t4_partial_frame", 32'(qn0.size() > 0 ? qn0[0] : -1), 32'd10);
        clear_q();
        frame_latency(0, 16'h1234, rdy_at, low);
        check("t4_rdy_latency", 32'(rdy_at), 32'd107);
        if (qb0.size() > 0) check("t4_frame", 32'(qb0[0]), 32'h001234);
        else check("t4_frame_count", 32'd0, 32'd1);

        // Fast instance: CLK_DIV=1, SETTLE_CYCLES=1, CMD_WORD=8'h30
        clear_q();
        frame_latency(1, 16'h8000, rdy_at, low);
        check("t5_rdy_latency", 32'(rdy_at), 32'd51);
        check("t5_sync_low_cycles", 32'(low), 32'd49);
        if (qb1.size() > 0) begin
            check("t5_frame", 32'(qb1[0]), 32'h308000);
            check("t5_sclk_edges", 32'(qn1[0]), 32'd24);
        end else check("t5_frame_count", 32'd0, 32'd1);

        // wre held high for 200 cycles
        clear_q();
        wre[0] = 1'b1; thr[0] = 16'hC0DE;
        repeat (200) tick();
        wre[0] = 1'b0;
        wait_rdy(0, n);
        check("t6_frame_count", 32'(qb0.size()), 32'd3);
        foreach (qb0[j]) begin
            check("t6_frame", 32'(qb0[j]), 32'h00C0DE);
            check("t6_frame_len", 32'(qn0[j]), 32'd24);
        end

        // Random writes on both instances, checked by the per-cycle model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                wre[i] = ($urandom_range(0, 39) == 0);
                thr[i] = 16'($urandom);
            end
            tick();
        end
        wre = 2'b00;
        wait_rdy(0, n);
        wait_rdy(1, n);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
